// File: rtl/lopd_norm_pipe.sv
// Pipelined leading-one position detector with a normalising left shift.
// Stage 1 registers the per-segment zero flags and local leading-one indices.
// Stage 2 merges the segments, computes the shift and barrel-shifts the data.
// Each stage has valid/ready flow control, and the pipeline holds at most two items.

// One segment: an all-zero flag and the index of its most significant set bit.
module lopd_seg #(
  parameter int SEG_W = 8,
  parameter int IDX_W = $clog2(SEG_W)
) (
  input  logic [SEG_W-1:0] i_seg,
  output logic             o_zero,
  output logic [IDX_W-1:0] o_idx
);

  // Scan upward so that the highest set bit is the one that sticks.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < SEG_W; i++) begin
      if (i_seg[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_zero = ~|i_seg;

endmodule

module lopd_norm_pipe #(
  parameter int DATA_W = 24,
  parameter int SEG_W  = 8,
  parameter int POS_W  = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [POS_W-1:0]  o_one_position,
  output logic              o_zero_flag,
  output logic [POS_W-1:0]  o_shift_amt,
  output logic [DATA_W-1:0] o_norm_data
);

  localparam int NSEG = DATA_W / SEG_W;
  localparam int LW   = $clog2(SEG_W);

  // Bit 1 is the stage-1 valid and bit 2 is the stage-2 valid.
  logic [2:1]                  r_vld_pipe;

  logic [DATA_W-1:0]           r_s1_data;
  logic [NSEG-1:0]             r_s1_segz;
  logic [NSEG-1:0][LW-1:0]     r_s1_lidx;

  logic [POS_W-1:0]            r_s2_pos;
  logic                        r_s2_zero;
  logic [POS_W-1:0]            r_s2_shift;
  logic [DATA_W-1:0]           r_s2_norm;

  logic [NSEG-1:0]             w_segz;
  logic [NSEG-1:0][LW-1:0]     w_lidx;
  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic                        w_s1_adv;
  logic [POS_W-1:0]            w_pos;
  logic                        w_zero;
  logic [POS_W-1:0]            w_shift;
  logic [DATA_W-1:0]           w_norm;

  // Handshake. o_ready depends only on the stage state and i_ready, never on i_valid.
  assign w_s1_adv   = r_vld_pipe[1] & (~r_vld_pipe[2] | i_ready);
  assign o_ready    = ~r_vld_pipe[1] | w_s1_adv;
  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = r_vld_pipe[2] & i_ready;

  // First-level detection: one lopd_seg instance per segment.
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    lopd_seg #(.SEG_W(SEG_W), .IDX_W(LW)) u_seg (
      .i_seg  (i_data[g*SEG_W +: SEG_W]),
      .o_zero (w_segz[g]),
      .o_idx  (w_lidx[g])
    );
  end

  // Stage 1: capture the segment summaries and the raw data on an input transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_s1_data     <= '0;
      r_s1_segz     <= '0;
      r_s1_lidx     <= '0;
    end else if (w_in_xfer) begin
      r_vld_pipe[1] <= 1'b1;
      r_s1_data     <= i_data;
      r_s1_segz     <= w_segz;
      r_s1_lidx     <= w_lidx;
    end else if (w_s1_adv) begin
      r_vld_pipe[1] <= 1'b0;
    end
  end

  // Pick the highest non-zero segment. The ascending loop lets the highest segment win.
  always_comb begin
    w_pos  = '0;
    w_zero = 1'b1;
    for (int k = 0; k < NSEG; k++) begin
      if (!r_s1_segz[k]) begin
        w_pos  = POS_W'(k * SEG_W) + POS_W'(r_s1_lidx[k]);
        w_zero = 1'b0;
      end
    end
  end

  // All-zero data needs no shift. Shifting zero data still gives zero.
  assign w_shift = w_zero ? '0 : (POS_W'(DATA_W - 1) - w_pos);
  assign w_norm  = r_s1_data << w_shift;

  // Stage 2: register the results on s1_adv. Outputs hold while the stage is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_s2_pos      <= '0;
      r_s2_zero     <= 1'b0;
      r_s2_shift    <= '0;
      r_s2_norm     <= '0;
    end else if (w_s1_adv) begin
      r_vld_pipe[2] <= 1'b1;
      r_s2_pos      <= w_pos;
      r_s2_zero     <= w_zero;
      r_s2_shift    <= w_shift;
      r_s2_norm     <= w_norm;
    end else if (w_out_xfer) begin
      r_vld_pipe[2] <= 1'b0;
    end
  end

  assign o_valid        = r_vld_pipe[2];
  assign o_one_position = r_s2_pos;
  assign o_zero_flag    = r_s2_zero;
  assign o_shift_amt    = r_s2_shift;
  assign o_norm_data    = r_s2_norm;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Directed, table-driven bench for lopd_norm_pipe (24-bit, plus a 32-bit instance).
module tb_lopd_norm_pipe;

  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, o_ready, o_valid, o_zero_flag;
  logic [23:0] i_data, o_norm_data;
  logic [4:0]  o_one_position, o_shift_amt;

  logic        w_valid_i, w_ready_i, w_ready_o, w_valid_o, w_zf;
  logic [31:0] w_data, w_norm;
  logic [4:0]  w_pos, w_sh;

  int total = 0;
  int bad   = 0;
  int rdy_low = 0;

  typedef struct {
    logic [23:0] din;
    logic [4:0]  pos;
    logic        zf;
    logic [4:0]  sh;
    logic [23:0] norm;
  } vec_t;

  vec_t tv [NV];

  always #5 clk = ~clk;

  lopd_norm_pipe #(.DATA_W(24), .SEG_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_one_position(o_one_position), .o_zero_flag(o_zero_flag),
    .o_shift_amt(o_shift_amt), .o_norm_data(o_norm_data)
  );

  lopd_norm_pipe #(.DATA_W(32), .SEG_W(8)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid_i), .o_ready(w_ready_o),
    .i_data(w_data), .o_valid(w_valid_o), .i_ready(w_ready_i),
    .o_one_position(w_pos), .o_zero_flag(w_zf),
    .o_shift_amt(w_sh), .o_norm_data(w_norm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string tag, input int k);
    chk({tag, "_pos"},  32'(o_one_position), 32'(tv[k].pos));
    chk({tag, "_zf"},   32'(o_zero_flag),    32'(tv[k].zf));
    chk({tag, "_sh"},   32'(o_shift_amt),    32'(tv[k].sh));
    chk({tag, "_norm"}, 32'(o_norm_data),    32'(tv[k].norm));
  endtask

  // One isolated item: accept, no result one cycle later, result after the next edge.
  task automatic apply_one(input int k);
    @(negedge clk);
    i_valid = 1'b1; i_data = tv[k].din; i_ready = 1'b1;
    #1 chk("one_rdy", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk("one_lat_vld0", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("one_vld", 32'(o_valid), 32'd1);
    chk_vec("one", k);
  endtask

  // Streams n table items. i_ready is held low for stall_len cycles from stall_at.
  // An occupancy model predicts o_ready, and the scoreboard checks the order.
  task automatic stream(input int n, input int stall_at, input int stall_len,
                        output int first_c, output int last_c);
    int sent, got, cyc, occ;
    logic in_x, out_x, prev_stall, p_zf;
    logic [4:0]  p_pos, p_sh;
    logic [23:0] p_norm;
    sent = 0; got = 0; cyc = 0; occ = 0; prev_stall = 1'b0;
    first_c = -1; last_c = -1;
    p_zf = 1'b0; p_pos = '0; p_sh = '0; p_norm = '0;
    while ((got < n) && (cyc < 300)) begin
      @(negedge clk);
      i_ready = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
      i_valid = (sent < n);
      i_data  = tv[sent % NV].din;
      #1;
      chk("str_rdy", 32'(o_ready), 32'((occ < 2) || i_ready));
      if (!o_ready) rdy_low++;
      if (prev_stall) begin
        chk("hold_vld",  32'(o_valid),        32'd1);
        chk("hold_pos",  32'(o_one_position), 32'(p_pos));
        chk("hold_zf",   32'(o_zero_flag),    32'(p_zf));
        chk("hold_sh",   32'(o_shift_amt),    32'(p_sh));
        chk("hold_norm", 32'(o_norm_data),    32'(p_norm));
      end
      out_x = o_valid && i_ready;
      if (out_x) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        chk_vec("str", got % NV);
        got++;
      end
      in_x = i_valid && o_ready;
      if (in_x) sent++;
      occ = occ + int'(in_x) - int'(out_x);
      prev_stall = o_valid && !i_ready;
      p_pos = o_one_position; p_zf = o_zero_flag; p_sh = o_shift_amt; p_norm = o_norm_data;
      cyc++;
    end
    chk("str_count", 32'(got), 32'(n));
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
  endtask

  initial begin
    int f, l;
    tv[0] = '{24'h800000, 5'd23, 1'b0, 5'd0,  24'h800000};
    tv[1] = '{24'h000001, 5'd0,  1'b0, 5'd23, 24'h800000};
    tv[2] = '{24'h00A000, 5'd15, 1'b0, 5'd8,  24'hA00000};
    tv[3] = '{24'h000000, 5'd0,  1'b1, 5'd0,  24'h000000};
    tv[4] = '{24'h000300, 5'd9,  1'b0, 5'd14, 24'hC00000};
    tv[5] = '{24'h0F0F0F, 5'd19, 1'b0, 5'd4,  24'hF0F0F0};
    tv[6] = '{24'h123456, 5'd20, 1'b0, 5'd3,  24'h91A2B0};
    tv[7] = '{24'h400000, 5'd22, 1'b0, 5'd1,  24'h800000};
    tv[8] = '{24'h000080, 5'd7,  1'b0, 5'd16, 24'h800000};
    tv[9] = '{24'hFFFFFF, 5'd23, 1'b0, 5'd0,  24'hFFFFFF};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
    w_valid_i = 1'b0; w_ready_i = 1'b1; w_data = '0;
    #1;
    chk("rst_vld",  32'(o_valid),        32'd0);
    chk("rst_pos",  32'(o_one_position), 32'd0);
    chk("rst_zf",   32'(o_zero_flag),    32'd0);
    chk("rst_sh",   32'(o_shift_amt),    32'd0);
    chk("rst_norm", 32'(o_norm_data),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rdy", 32'(o_ready), 32'd1);

    // Isolated items covering every table entry.
    for (int k = 0; k < NV; k++) apply_one(k);

    // Ten back-to-back items with i_ready=1. The results must come out in ten consecutive cycles.
    stream(10, 1000, 0, f, l);
    chk("b2b_span", 32'(l - f), 32'd9);
    chk("b2b_rdy_low", 32'(rdy_low), 32'd0);

    // i_ready low for 4 cycles: o_ready drops for the two cycles the pipeline is full.
    rdy_low = 0;
    stream(6, 0, 4, f, l);
    chk("stall_rdy_low", 32'(rdy_low), 32'd2);

    // Asynchronous reset in mid-stream, between clock edges.
    @(negedge clk);
    i_valid = 1'b1; i_data = 24'h123456; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_vld",  32'(o_valid),     32'd1);
    chk("pre_rst_norm", 32'(o_norm_data), 32'h91A2B0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld",  32'(o_valid),        32'd0);
    chk("arst_pos",  32'(o_one_position), 32'd0);
    chk("arst_zf",   32'(o_zero_flag),    32'd0);
    chk("arst_sh",   32'(o_shift_amt),    32'd0);
    chk("arst_norm", 32'(o_norm_data),    32'd0);
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_vld", 32'(o_valid), 32'd0);
    end
    apply_one(2);

    // 32-bit instance.
    @(negedge clk);
    w_valid_i = 1'b1; w_data = 32'h00010000;
    @(negedge clk);
    w_valid_i = 1'b1; w_data = 32'h80000001;
    @(negedge clk);
    w_valid_i = 1'b0;
    chk("w32_vld",  32'(w_valid_o), 32'd1);
    chk("w32_pos",  32'(w_pos),     32'd16);
    chk("w32_sh",   32'(w_sh),      32'd15);
    chk("w32_zf",   32'(w_zf),      32'd0);
    chk("w32_norm", w_norm,         32'h80000000);
    @(negedge clk);
    chk("w32b_vld",  32'(w_valid_o), 32'd1);
    chk("w32b_pos",  32'(w_pos),     32'd31);
    chk("w32b_sh",   32'(w_sh),      32'd0);
    chk("w32b_norm", w_norm,         32'h80000001);
    @(negedge clk);
    chk("w32_drain", 32'(w_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lopd_norm_pipe.md
Name: lopd_norm_pipe

Overview:
- Parametrised, pipelined leading-one position detector with normalising left shift.
- Generalises the fixed 24-bit combinational LOPD to any DATA_W that is a multiple of SEG_W.
- Adds a two-stage register pipeline with valid/ready flow control on both sides.
- Sits between the mantissa adder and the rounding stage of the floating-point datapath.

Parameters:
- DATA_W, 24, input data width; must be a multiple of SEG_W, minimum 2*SEG_W.
- SEG_W, 8, segment width for first-level detection; must be a power of 2.
- POS_W, $clog2(DATA_W), width of the position and shift outputs.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream presents i_data.
- o_ready  output  1  block can accept i_data this cycle.
- i_data  input  DATA_W  operand.
- o_valid  output  1  result outputs are valid.
- i_ready  input  1  downstream accepts the result this cycle.
- o_one_position  output  POS_W  bit index of the most significant 1 in the accepted data.
- o_zero_flag  output  1  accepted data was all zeros.
- o_shift_amt  output  POS_W  equals DATA_W-1-o_one_position; 0 when o_zero_flag.
- o_norm_data  output  DATA_W  accepted data shifted left by o_shift_amt (MSB at bit DATA_W-1).

Behaviour:
- Clock and reset: one clock domain, i_clk. Asynchronous active-low reset i_rst_n.
- Reset state: both stage valid bits are 0 and all stage registers are 0.
  - Outputs: o_valid=0, o_one_position=0, o_zero_flag=0, o_shift_amt=0, o_norm_data=0.
  - o_ready=1 once i_rst_n is deasserted.
- Reset asserted mid-operation: clears both stages immediately, without waiting for a clock edge. In-flight data is dropped.
- Handshake: a transfer occurs on an edge where valid&ready are both 1, on either side.
  - o_ready = ~s1_valid | s1_adv.
  - s1_adv = s1_valid & (~s2_valid | (i_ready)).
  - o_ready is combinational from i_ready. No combinational path from i_valid to o_ready.
- Stage 1, on input transfer:
  - Split i_data into NSEG = DATA_W/SEG_W segments.
  - Per segment, register its zero flag and its local leading-one index (log2(SEG_W) bits).
  - Also register i_data.
  - If no transfer while s1_adv, s1_valid clears.
- Stage 2, on s1_adv:
  - Select the highest-indexed non-zero segment k.
  - Position = k*SEG_W + local index; zero flag = AND of all segment zero flags.
  - Compute shift and barrel-shift the data, then register all four results.
  - s2_valid is set on s1_adv and cleared on output transfer without s1_adv.
- Latency and throughput:
  - Latency is 2 cycles: data accepted at edge N appears with o_valid=1 after edge N+1.
  - Throughput is 1 result per cycle while i_ready=1.
- Stall rules:
  - While o_valid=1 and i_ready=0, all outputs hold stable.
  - The pipeline holds at most 2 items; o_ready=0 only when both stages are full and i_ready=0.
  - Ordering is preserved and no item is lost or duplicated.
- All-zero input: o_zero_flag=1, o_one_position=0, o_shift_amt=0, o_norm_data=0.
- Simultaneous input and output transfer with both stages full: both stages advance in the same edge.
- Outputs are registered (no combinational path from i_data to the result outputs).

Test Plan:
- Single 24'h800000 with i_ready=1 -> o_valid two edges after accept, with o_one_position=23, o_shift_amt=0, o_norm_data=24'h800000, o_zero_flag=0.
- 24'h000001 -> position 0, shift 23, o_norm_data=24'h800000; then 24'h00A000 -> position 15, shift 8, o_norm_data=24'hA00000.
- 24'h000000 -> o_zero_flag=1, position 0, shift 0, o_norm_data=0.
- 10 back-to-back inputs with i_ready=1 -> 10 consecutive o_valid cycles in input order, and o_ready stays 1 throughout.
- Stream with i_ready=0 for 4 cycles -> o_ready drops after 2 items are captured. Outputs are held stable, and all items emerge in order once i_ready=1.
- i_rst_n pulsed low mid-stream -> o_valid=0 and outputs go to 0 without waiting for a clock edge; no stale result afterwards.
- Rerun with DATA_W=32 on input 32'h00010000 -> position 16, shift 15.
